afu_write_ctrl: RTL and testbench

- Write-back stage directly downstream of the AFU user block.
- Drains the 512-bit output FIFO, which is synchronous-read: dout is valid the cycle after re.
- Issues one host write request per cache line at consecutive line addresses from a context base address, with host backpressure and bounded outstanding writes.
- Counts write responses and raises done when all ctx_length lines are acknowledged.

---
 rtl/afu_write_ctrl.sv | 176 +++++++++++++++++
 tb/tb_afu_write_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afu_write_ctrl.sv
// Write-back stage: drains the AFU output FIFO into host write requests at consecutive line addresses.
// Latency: FIFO read enable to wr_req_valid is exactly 2 cycles; back-to-back reads give back-to-back requests.
// Backpressure: reads stall on FIFO empty, host almost-full, or MAX_OUTSTANDING unacknowledged lines.
module afu_write_ctrl #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned MAX_OUTSTANDING = 32,
    parameter int unsigned OUT_BITS        = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           ctx_length,
    input  logic [ADDR_WIDTH-1:0] ctx_base_addr,
    input  logic [DATA_WIDTH-1:0] output_fifo_dout,
    input  logic                  output_fifo_empty,
    output logic                  output_fifo_re,
    output logic                  wr_req_valid,
    output logic [ADDR_WIDTH-1:0] wr_req_addr,
    output logic [DATA_WIDTH-1:0] wr_req_data,
    input  logic                  wr_req_almost_full,
    input  logic                  wr_rsp_valid,
    output logic                  done,
    output logic                  rsp_error,
    output logic [31:0]           wr_rsp_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [OUT_BITS-1:0] MAX_OUT = OUT_BITS'(MAX_OUTSTANDING);

    state_t                  state_q, state_d;
    logic [31:0]             len_q, len_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             rd_cnt_q, rd_cnt_d;
    logic [OUT_BITS-1:0]     out_cnt_q, out_cnt_d;
    logic                    rd_v_q, rd_v_d;
    logic                    wr_req_valid_q, wr_req_valid_d;
    logic [ADDR_WIDTH-1:0]   wr_req_addr_q, wr_req_addr_d;
    logic [DATA_WIDTH-1:0]   wr_req_data_q, wr_req_data_d;
    logic                    done_q, done_d;
    logic                    rsp_error_q, rsp_error_d;
    logic [31:0]             wr_rsp_count_q, wr_rsp_count_d;

    logic fifo_re;
    logic ctx_active;
    logic rsp_accept;
    logic rsp_spurious;

    // Gating with reset keeps the read enable low for the whole reset window.
    assign fifo_re = reset
                   & (state_q == RUN)
                   & ~output_fifo_empty
                   & (rd_cnt_q < len_q)
                   & ~wr_req_almost_full
                   & (out_cnt_q < MAX_OUT);

    assign ctx_active   = (state_q == RUN) || (state_q == WAIT_RSP);
    assign rsp_accept   = wr_rsp_valid & ctx_active & (out_cnt_q != '0);
    assign rsp_spurious = wr_rsp_valid & ~rsp_accept;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        base_d         = base_q;
        idx_d          = idx_q;
        rd_cnt_d       = rd_cnt_q;
        out_cnt_d      = out_cnt_q;
        rd_v_d         = fifo_re;
        wr_req_valid_d = rd_v_q;
        wr_req_addr_d  = wr_req_addr_q;
        wr_req_data_d  = wr_req_data_q;
        done_d         = done_q;
        rsp_error_d    = rsp_error_q;
        wr_rsp_count_d = wr_rsp_count_q;

        // FIFO data is valid the cycle after the read; capture it alongside its line address.
        if (rd_v_q) begin
            wr_req_data_d = output_fifo_dout;
            wr_req_addr_d = base_q + idx_q;
            idx_d         = idx_q + 1'b1;
        end

        if (fifo_re) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end

        case ({fifo_re, rsp_accept})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase

        if (rsp_accept && (wr_rsp_count_q != len_q)) begin
            wr_rsp_count_d = wr_rsp_count_q + 32'd1;
        end
        if (rsp_spurious) begin
            rsp_error_d = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d          = ctx_length;
                    base_d         = ctx_base_addr;
                    idx_d          = '0;
                    rd_cnt_d       = '0;
                    out_cnt_d      = '0;
                    wr_rsp_count_d = '0;
                    rsp_error_d    = 1'b0;
                    done_d         = (ctx_length == 32'd0);
                    state_d        = (ctx_length == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_cnt_q == len_q) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (wr_rsp_count_q == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            base_q         <= '0;
            idx_q          <= '0;
            rd_cnt_q       <= '0;
            out_cnt_q      <= '0;
            rd_v_q         <= 1'b0;
            wr_req_valid_q <= 1'b0;
            wr_req_addr_q  <= '0;
            wr_req_data_q  <= '0;
            done_q         <= 1'b0;
            rsp_error_q    <= 1'b0;
            wr_rsp_count_q <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            base_q         <= base_d;
            idx_q          <= idx_d;
            rd_cnt_q       <= rd_cnt_d;
            out_cnt_q      <= out_cnt_d;
            rd_v_q         <= rd_v_d;
            wr_req_valid_q <= wr_req_valid_d;
            wr_req_addr_q  <= wr_req_addr_d;
            wr_req_data_q  <= wr_req_data_d;
            done_q         <= done_d;
            rsp_error_q    <= rsp_error_d;
            wr_rsp_count_q <= wr_rsp_count_d;
        end
    end

    assign output_fifo_re = fifo_re;
    assign wr_req_valid   = wr_req_valid_q;
    assign wr_req_addr    = wr_req_addr_q;
    assign wr_req_data    = wr_req_data_q;
    assign done           = done_q;
    assign rsp_error      = rsp_error_q;
    assign wr_rsp_count   = wr_rsp_count_q;

endmodule

// File: tb/tb_afu_write_ctrl.sv
// Bench for afu_write_ctrl: table of whole contexts with auto-responding host, then hand sequences
// for outstanding limit, almost-full stall, zero length, spurious responses and asynchronous reset.
module tb_afu_write_ctrl;

    localparam int AW = 32;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   ctx_length;
    logic [AW-1:0] ctx_base_addr;
    logic [DW-1:0] output_fifo_dout;
    logic          output_fifo_empty;
    logic          output_fifo_re;
    logic          wr_req_valid;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic          wr_req_almost_full;
    logic          wr_rsp_valid;
    logic          done;
    logic          rsp_error;
    logic [31:0]   wr_rsp_count;

    always #5 clk = ~clk;

    afu_write_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(32), .OUT_BITS(6)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .ctx_length(ctx_length), .ctx_base_addr(ctx_base_addr),
        .output_fifo_dout(output_fifo_dout), .output_fifo_empty(output_fifo_empty),
        .output_fifo_re(output_fifo_re),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_almost_full(wr_req_almost_full), .wr_rsp_valid(wr_rsp_valid),
        .done(done), .rsp_error(rsp_error), .wr_rsp_count(wr_rsp_count)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fifo_mem [0:127];
    int fifo_wr, fifo_rd;
    int cyc = 0;
    int start_cyc;
    int first_req_cyc, last_req_cyc;
    int re_cnt;
    int pending;
    bit auto_rsp;
    logic [AW-1:0] req_addr_log[$];
    logic [DW-1:0] req_data_log[$];

    typedef struct {
        int          len;
        logic [31:0] base;
        logic [31:0] exp_last;
        int          exp_lat;
    } vec_t;

    vec_t tbl[4];

    function automatic logic [DW-1:0] line_pat(int tag, int k);
        logic [15:0] t16, k16;
        t16 = tag[15:0];
        k16 = k[15:0];
        return {16{t16, k16}};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock: sample DUT outputs before the edge, then advance the FIFO and host models.
    task automatic tick();
        logic re_s, vld_s;
        logic [AW-1:0] a_s;
        logic [DW-1:0] d_s;
        @(negedge clk);
        re_s  = output_fifo_re;
        vld_s = wr_req_valid;
        a_s   = wr_req_addr;
        d_s   = wr_req_data;
        @(posedge clk);
        #1;
        cyc++;
        if (re_s) begin
            output_fifo_dout = fifo_mem[fifo_rd % 128];
            fifo_rd++;
            re_cnt++;
        end
        output_fifo_empty = (fifo_rd >= fifo_wr);
        if (vld_s) begin
            req_addr_log.push_back(a_s);
            req_data_log.push_back(d_s);
            pending++;
            if (first_req_cyc < 0) first_req_cyc = cyc - 1;
            last_req_cyc = cyc - 1;
        end
        if (auto_rsp) begin
            if (pending > 0) begin
                wr_rsp_valid = 1'b1;
                pending--;
            end else begin
                wr_rsp_valid = 1'b0;
            end
        end
    endtask

    task automatic reset_all();
        reset              = 1'b0;
        start              = 1'b0;
        ctx_length         = '0;
        ctx_base_addr      = '0;
        output_fifo_dout   = '0;
        output_fifo_empty  = 1'b1;
        wr_req_almost_full = 1'b0;
        wr_rsp_valid       = 1'b0;
        fifo_wr = 0; fifo_rd = 0; pending = 0; auto_rsp = 0; re_cnt = 0;
        first_req_cyc = -1; last_req_cyc = -1;
        req_addr_log.delete(); req_data_log.delete();
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic preload(int tag, int n);
        for (int k = 0; k < n; k++) begin
            fifo_mem[fifo_wr % 128] = line_pat(tag, k);
            fifo_wr++;
        end
        output_fifo_empty = (fifo_rd >= fifo_wr);
    endtask

    task automatic start_ctx(int len, logic [31:0] base);
        ctx_length    = len;
        ctx_base_addr = base;
        start         = 1'b1;
        start_cyc     = cyc;
        first_req_cyc = -1;
        last_req_cyc  = -1;
        re_cnt        = 0;
        req_addr_log.delete(); req_data_log.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(int max_cycles);
        for (int i = 0; i < max_cycles && !done; i++) tick();
        chk("done_reached", done, 1);
    endtask

    task automatic check_stream(string nm, logic [31:0] base, int n, int tag);
        logic [31:0] ea;
        chk({nm, "_req_count"}, req_addr_log.size(), n);
        for (int i = 0; i < n && i < req_addr_log.size(); i++) begin
            ea = base + i;
            chk({nm, "_addr"}, req_addr_log[i], ea);
            chk({nm, "_data"}, req_data_log[i] == line_pat(tag, i), 1);
        end
    endtask

    task automatic rsp_pulse(int n);
        wr_rsp_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            pending--;
            tick();
        end
        wr_rsp_valid = 1'b0;
    endtask

    initial begin
        int before_re, before_req;

        tbl[0] = '{len: 4, base: 32'h0000_0100, exp_last: 32'h0000_0103, exp_lat: 3};
        tbl[1] = '{len: 3, base: 32'hFFFF_FFFE, exp_last: 32'h0000_0000, exp_lat: 3};
        tbl[2] = '{len: 1, base: 32'h0000_0000, exp_last: 32'h0000_0000, exp_lat: 3};
        tbl[3] = '{len: 6, base: 32'h7FFF_FFFD, exp_last: 32'h8000_0002, exp_lat: 3};

        // Reset state, observed while reset is still low.
        reset = 1'b0; start = 1'b0; ctx_length = '0; ctx_base_addr = '0;
        output_fifo_dout = '0; output_fifo_empty = 1'b0; wr_req_almost_full = 1'b0;
        wr_rsp_valid = 1'b0;
        #1;
        chk("rst_re", output_fifo_re, 0);
        chk("rst_valid", wr_req_valid, 0);
        chk("rst_addr", wr_req_addr, 0);
        chk("rst_data", wr_req_data == '0, 1);
        chk("rst_done", done, 0);
        chk("rst_err", rsp_error, 0);
        chk("rst_count", wr_rsp_count, 0);

        // Whole contexts with an immediately responding host.
        for (int v = 0; v < 4; v++) begin
            reset_all();
            auto_rsp = 1;
            preload(v + 1, tbl[v].len);
            start_ctx(tbl[v].len, tbl[v].base);
            wait_done(300);
            chk("tbl_count", wr_rsp_count, tbl[v].len);
            chk("tbl_err", rsp_error, 0);
            chk("tbl_latency", first_req_cyc - start_cyc, tbl[v].exp_lat);
            chk("tbl_back2back", last_req_cyc - first_req_cyc, tbl[v].len - 1);
            if (req_addr_log.size() > 0)
                chk("tbl_last_addr", req_addr_log[req_addr_log.size() - 1], tbl[v].exp_last);
            check_stream("tbl", tbl[v].base, tbl[v].len, v + 1);
            repeat (3) tick();
            chk("tbl_done_held", done, 1);
            chk("tbl_no_extra", req_addr_log.size(), tbl[v].len);
        end

        // Zero-length context completes without touching the FIFO.
        reset_all();
        preload(20, 2);
        start_ctx(0, 32'h55);
        chk("zero_done_next", done, 1);
        repeat (5) tick();
        chk("zero_re", re_cnt, 0);
        chk("zero_reqs", req_addr_log.size(), 0);
        chk("zero_done_held", done, 1);

        // Outstanding limit with responses withheld.
        reset_all();
        preload(7, 64);
        start_ctx(64, 32'h2000);
        repeat (45) tick();
        chk("out_limit_reads", re_cnt, 32);
        chk("out_limit_re_low", output_fifo_re, 0);
        rsp_pulse(1);
        repeat (5) tick();
        chk("out_one_frees_one", re_cnt, 33);
        rsp_pulse(2);
        repeat (5) tick();
        chk("out_simul_rd_rsp", re_cnt, 35);
        chk("out_rsp_count", wr_rsp_count, 3);
        auto_rsp = 1;
        wait_done(500);
        chk("out_final_count", wr_rsp_count, 64);
        check_stream("out", 32'h2000, 64, 7);

        // Host almost-full stalls reads; at most two requests already in flight.
        reset_all();
        auto_rsp = 1;
        preload(9, 40);
        start_ctx(40, 32'h4000);
        repeat (6) tick();
        wr_req_almost_full = 1'b1;
        before_re  = re_cnt;
        before_req = req_addr_log.size();
        repeat (10) tick();
        chk("af_no_reads", re_cnt - before_re, 0);
        chk("af_max2_reqs", (req_addr_log.size() - before_req) <= 2, 1);
        wr_req_almost_full = 1'b0;
        wait_done(300);
        check_stream("af", 32'h4000, 40, 9);

        // Spurious response in IDLE.
        reset_all();
        wr_rsp_valid = 1'b1;
        tick();
        wr_rsp_valid = 1'b0;
        chk("spur_err", rsp_error, 1);
        chk("spur_count", wr_rsp_count, 0);

        // Asynchronous reset in RUN, then a late response.
        preload(11, 8);
        start_ctx(8, 32'h9000);
        chk("start_clears_err", rsp_error, 0);
        repeat (4) tick();
        rsp_pulse(1);
        chk("pre_rst_valid", wr_req_valid, 1);
        chk("pre_rst_count", wr_rsp_count, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_re", output_fifo_re, 0);
        chk("arst_valid", wr_req_valid, 0);
        chk("arst_addr", wr_req_addr, 0);
        chk("arst_data", wr_req_data == '0, 1);
        chk("arst_done", done, 0);
        chk("arst_count", wr_rsp_count, 0);
        tick();
        reset = 1'b1;
        tick();
        wr_rsp_valid = 1'b1;
        tick();
        wr_rsp_valid = 1'b0;
        chk("late_rsp_err", rsp_error, 1);
        chk("late_rsp_count", wr_rsp_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
